// File: rtl/stack_guard.sv
// Guard between the J1a core and its hardware stack: maps stack deltas to push/pop strobes,
// tracks depth, and traps on overflow/underflow/illegal delta. Optional macro: STACK_GUARD_HWM_EN.
module stack_guard #(
    parameter int unsigned DEPTHLOG2 = 3,
    parameter int unsigned PCWIDTH   = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [1:0]           req_delta,
    input  logic                 req_wr,
    input  logic [PCWIDTH-1:0]   req_pc,
    input  logic                 flush,
    input  logic                 trap_ack,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [DEPTHLOG2:0]   depth,
    output logic                 stall,
    output logic                 trap_req,
    output logic [1:0]           fault_code,
    output logic [PCWIDTH-1:0]   fault_pc
`ifdef STACK_GUARD_HWM_EN
    ,
    input  logic                 hwm_clr,
    output logic [DEPTHLOG2:0]   hwm
`endif
);

    localparam int unsigned DW  = DEPTHLOG2 + 1;
    localparam int unsigned CAP = 1 << DEPTHLOG2;

    localparam logic [1:0] DELTA_ZERO = 2'b00;
    localparam logic [1:0] DELTA_INC  = 2'b01;
    localparam logic [1:0] DELTA_BAD  = 2'b10;
    localparam logic [1:0] DELTA_DEC  = 2'b11;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_OVER  = 2'b01;
    localparam logic [1:0] FC_UNDER = 2'b10;
    localparam logic [1:0] FC_ILL   = 2'b11;

    typedef enum logic {RUN, TRAP} state_t;

    state_t     state;
    logic       fault_c;
    logic [1:0] fcode_c;
    logic       at_cap_c;
    logic       empty_c;

    assign at_cap_c = (depth == DW'(CAP));
    assign empty_c  = (depth == '0);

    // Request decode: strobes and fault detection; flush or TRAP drops the request outright.
    always_comb begin
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        fault_c  = 1'b0;
        fcode_c  = FC_NONE;
        if (state == RUN && req_valid && !flush) begin
            case (req_delta)
                DELTA_BAD: begin
                    fault_c = 1'b1;
                    fcode_c = FC_ILL;
                end
                DELTA_INC: begin
                    if (at_cap_c) begin
                        fault_c = 1'b1;
                        fcode_c = FC_OVER;
                    end else begin
                        stk_push = 1'b1;
                    end
                end
                DELTA_DEC: begin
                    if (empty_c) begin
                        fault_c = 1'b1;
                        fcode_c = FC_UNDER;
                    end else begin
                        stk_pop = 1'b1;
                    end
                end
                DELTA_ZERO: begin
                    if (req_wr) begin
                        if (empty_c) begin
                            fault_c = 1'b1;
                            fcode_c = FC_UNDER;
                        end else begin
                            stk_push = 1'b1;
                            stk_pop  = 1'b1;
                        end
                    end
                end
                default: begin
                    fault_c = 1'b0;
                end
            endcase
        end
    end

    // Depth tracking and trap state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            depth      <= '0;
            trap_req   <= 1'b0;
            stall      <= 1'b0;
            fault_code <= FC_NONE;
            fault_pc   <= '0;
        end else begin
            if (flush) begin
                depth <= '0;
            end else if (stk_push && !stk_pop) begin
                depth <= DW'(depth + DW'(1));
            end else if (stk_pop && !stk_push) begin
                depth <= DW'(depth - DW'(1));
            end

            case (state)
                RUN: begin
                    if (fault_c) begin
                        state      <= TRAP;
                        trap_req   <= 1'b1;
                        stall      <= 1'b1;
                        fault_code <= fcode_c;
                        fault_pc   <= req_pc;
                    end
                end
                TRAP: begin
                    // fault_pc deliberately survives the acknowledge for post-mortem reads.
                    if (trap_ack) begin
                        state      <= RUN;
                        trap_req   <= 1'b0;
                        stall      <= 1'b0;
                        fault_code <= FC_NONE;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef STACK_GUARD_HWM_EN
    // High-water mark follows the registered depth one cycle later; clear re-seeds from current depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            hwm <= '0;
        end else if (hwm_clr) begin
            hwm <= depth;
        end else if (depth > hwm) begin
            hwm <= depth;
        end
    end
`endif

endmodule

// File: doc/stack_guard.md
Name: stack_guard

Overview:
- Sits directly upstream of the J1a data/return hardware stack.
- Translates per-cycle CPU stack requests (signed delta plus write flag) into the stack's push/pop strobes.
- Tracks live depth and blocks any request that would overflow or underflow the on-chip stack, or that uses an illegal delta.
- On such a fault, latches a fault code and PC, stalls the core, and raises a trap request held until acknowledged.

Parameters:
- DEPTHLOG2, 3, log2 of downstream stack entries; capacity CAP = 2^DEPTHLOG2.
- PCWIDTH, 13, width of instruction address captured on fault.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- req_valid  input  1  CPU stack request this cycle.
- req_delta  input  2  signed stack delta: 00=0, 01=+1, 11=-1, 10=-2 (illegal).
- req_wr  input  1  with delta 0: overwrite top entry. Ignored for other deltas.
- req_pc  input  PCWIDTH  PC of the requesting instruction.
- flush  input  1  discard stack contents (ABORT/trap handler); depth to 0.
- trap_ack  input  1  trap handler acknowledges the fault.
- stk_push  output  1  push strobe to stack.
- stk_pop  output  1  pop strobe to stack (push&pop together = replace top).
- depth  output  DEPTHLOG2+1  current entry count, 0..CAP.
- stall  output  1  core must hold; high whenever in TRAP.
- trap_req  output  1  fault pending.
- fault_code  output  2  00 none, 01 overflow, 10 underflow, 11 illegal delta.
- fault_pc  output  PCWIDTH  req_pc of faulting request.

Behaviour:
- Reset values: depth=0, state RUN, trap_req=0, stall=0, fault_code=00, fault_pc=0, stk_push=stk_pop=0.
- stk_push/stk_pop are combinational from the request and registered state (zero latency). The downstream stack registers them.
- Legal mapping in RUN, req_valid=1:
  - +1 → push, depth+1.
  - 0 with wr → push+pop, depth unchanged.
  - 0 without wr → nothing.
  - -1 → pop, depth-1.
- Fault checks (RUN, req_valid=1), first match wins:
  1. delta 10 → illegal (11).
  2. +1 with depth==CAP → overflow (01).
  3. -1 with depth==0, or 0+wr with depth==0 → underflow (10).
- On fault:
  - No strobe is issued and depth is unchanged.
  - Next cycle: state TRAP, trap_req=1, stall=1, fault_code and fault_pc latched.
- TRAP:
  - All requests suppressed (no strobes), regardless of req_valid.
  - fault_code and fault_pc hold.
  - trap_ack → RUN next cycle; trap_req, stall, and fault_code clear to 0. fault_pc holds its last value.
- trap_ack in RUN is ignored.
- flush in any state: depth=0 next cycle, and the same-cycle request is dropped (no strobes, no fault check). flush does not leave TRAP.
- flush and trap_ack together in TRAP: both take effect (depth=0, RUN).
- push+pop at depth==CAP is legal (no overflow).
- depth never wraps; the guard guarantees 0 ≤ depth ≤ CAP.
- reset mid-TRAP returns to RUN with all reset values.

Optional Feature:
- Macro STACK_GUARD_HWM_EN.
- When defined:
  - Adds input hwm_clr (1) and output hwm (DEPTHLOG2+1).
  - hwm = maximum depth reached since reset/hwm_clr, updated the cycle after depth changes.
  - hwm_clr sets hwm to the current depth next cycle; hwm_clr has priority over a same-cycle update.
  - Reset sets hwm to 0.
- When undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- DEPTHLOG2=3, nine +1 requests at pc 0x100..0x108 → eight push strobes, depth=8. The 9th issues no strobe; next cycle trap_req=1, stall=1, fault_code=01, fault_pc=0x108.
- From reset, -1 at pc 0x020 → no pop, depth=0, fault_code=10, fault_pc=0x020. trap_ack → next cycle trap_req=0, fault_code=00.
- depth=3, delta 10 → fault_code=11, depth stays 3. Requests held valid during TRAP produce zero strobes.
- depth=8, delta 0 with wr → push=pop=1, depth=8, no fault. At depth=0, the same request → underflow.
- depth=5, flush with simultaneous +1 → no strobe, depth=0 next cycle. Then reset during TRAP → RUN, all outputs at reset values.
- STACK_GUARD_HWM_EN: push 6, pop 4 → hwm=6. hwm_clr → hwm=2. Push 1 → hwm=3.
